// File: rtl/vex_int_pkg.sv
// Shared types, funct6 encodings and op decode for the vector integer execute stage.
// Optional feature macro: CELLRV32_VEX_MUL_EN (adds vmul as an element op).
package cellrv32_package;

  localparam int VEX_ELEN   = 32;
  localparam int VEX_REG_AW = 5;
  localparam int VEX_VL_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RDC    = 2'd1,
    S_RDC_WB = 2'd2
  } vex_state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_MINU = 4'd5,
    OP_MIN  = 4'd6,
    OP_MAXU = 4'd7,
    OP_MAX  = 4'd8,
    OP_MUL  = 4'd9,
    OP_BAD  = 4'd15
  } vex_op_t;

  localparam logic [5:0] F6_VADD  = 6'b000000;
  localparam logic [5:0] F6_VSUB  = 6'b000010;
  localparam logic [5:0] F6_VMINU = 6'b000100;
  localparam logic [5:0] F6_VMIN  = 6'b000101;
  localparam logic [5:0] F6_VMAXU = 6'b000110;
  localparam logic [5:0] F6_VMAX  = 6'b000111;
  localparam logic [5:0] F6_VAND  = 6'b001001;
  localparam logic [5:0] F6_VOR   = 6'b001010;
  localparam logic [5:0] F6_VXOR  = 6'b001011;
  localparam logic [5:0] F6_VMUL  = 6'b100101;

  localparam logic [5:0] F6_VREDSUM  = 6'b000000;
  localparam logic [5:0] F6_VREDAND  = 6'b000001;
  localparam logic [5:0] F6_VREDOR   = 6'b000010;
  localparam logic [5:0] F6_VREDXOR  = 6'b000011;
  localparam logic [5:0] F6_VREDMINU = 6'b000100;
  localparam logic [5:0] F6_VREDMIN  = 6'b000101;
  localparam logic [5:0] F6_VREDMAXU = 6'b000110;
  localparam logic [5:0] F6_VREDMAX  = 6'b000111;

  typedef struct packed {
    logic                valid;
    logic [VEX_ELEN-1:0] data1;
    logic [VEX_ELEN-1:0] data2;
    logic                mask;
  } to_vector_exec;

  typedef struct packed {
    logic [5:0]            funct6;
    logic [2:0]            funct3;
    logic [VEX_REG_AW-1:0] dst;
    logic                  head_uop;
    logic                  end_uop;
    logic                  is_rdc;
    logic [VEX_VL_W-1:0]   vl;
  } to_vector_exec_info;

  // Reductions share funct6 values with element ops, so is_rdc selects the table.
  function automatic vex_op_t vex_decode(input logic [5:0] funct6, input logic is_rdc);
    vex_op_t op;
    op = OP_BAD;
    if (is_rdc) begin
      case (funct6)
        F6_VREDSUM:  op = OP_ADD;
        F6_VREDAND:  op = OP_AND;
        F6_VREDOR:   op = OP_OR;
        F6_VREDXOR:  op = OP_XOR;
        F6_VREDMINU: op = OP_MINU;
        F6_VREDMIN:  op = OP_MIN;
        F6_VREDMAXU: op = OP_MAXU;
        F6_VREDMAX:  op = OP_MAX;
        default:     op = OP_BAD;
      endcase
    end else begin
      case (funct6)
        F6_VADD:  op = OP_ADD;
        F6_VSUB:  op = OP_SUB;
        F6_VAND:  op = OP_AND;
        F6_VOR:   op = OP_OR;
        F6_VXOR:  op = OP_XOR;
        F6_VMINU: op = OP_MINU;
        F6_VMIN:  op = OP_MIN;
        F6_VMAXU: op = OP_MAXU;
        F6_VMAX:  op = OP_MAX;
`ifdef CELLRV32_VEX_MUL_EN
        F6_VMUL:  op = OP_MUL;
`endif
        default:  op = OP_BAD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/vex_int_if.sv
// Issue-stage <-> vector integer execute bundle: µop in, ready and writeback out.
// slave = execute unit side, master = issue stage side.
interface vex_int_if #(
  parameter int VECTOR_REGISTERS = 32,
  parameter int VECTOR_LANES     = 8,
  parameter int DATA_WIDTH       = 32
);
  import cellrv32_package::*;

  localparam int AW = $clog2(VECTOR_REGISTERS);

  logic                                valid_i;
  to_vector_exec [VECTOR_LANES-1:0]    data_i;
  to_vector_exec_info                  info_i;
  logic                                ready_o;
  logic [VECTOR_LANES-1:0]             wr_en_o;
  logic [AW-1:0]                       wr_addr_o;
  logic [VECTOR_LANES*DATA_WIDTH-1:0]  wr_data_o;
  logic                                illegal_o;
  logic                                busy_o;

  modport slave (
    input  valid_i, data_i, info_i,
    output ready_o, wr_en_o, wr_addr_o, wr_data_o, illegal_o, busy_o
  );

  modport master (
    output valid_i, data_i, info_i,
    input  ready_o, wr_en_o, wr_addr_o, wr_data_o, illegal_o, busy_o
  );
endinterface

// File: rtl/vex_int_alu.sv
// Combinational single-lane integer op: res = b op a (vsub is b - a), modulo 2^DATA_WIDTH.
// Unsupported ops produce zero.
module vex_int_alu
  import cellrv32_package::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  vex_op_t               op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:  res_o = b_i + a_i;
      OP_SUB:  res_o = b_i - a_i;
      OP_AND:  res_o = b_i & a_i;
      OP_OR:   res_o = b_i | a_i;
      OP_XOR:  res_o = b_i ^ a_i;
      OP_MINU: res_o = (b_i < a_i) ? b_i : a_i;
      OP_MIN:  res_o = ($signed(b_i) < $signed(a_i)) ? b_i : a_i;
      OP_MAXU: res_o = (b_i > a_i) ? b_i : a_i;
      OP_MAX:  res_o = ($signed(b_i) > $signed(a_i)) ? b_i : a_i;
      OP_MUL:  res_o = b_i * a_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/vex_int.sv
// Vector integer execute stage: per-lane element ops with 1-cycle writeback, and
// multi-µop reductions accumulated in S_RDC and written back from S_RDC_WB.
module vex_int
  import cellrv32_package::*;
#(
  parameter int VECTOR_REGISTERS = 32,
  parameter int VECTOR_LANES     = 8,
  parameter int DATA_WIDTH       = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  vex_int_if.slave   bus
);

  localparam int AW = $clog2(VECTOR_REGISTERS);

  vex_state_t                         state_q, state_d;
  logic [DATA_WIDTH-1:0]              acc_q, acc_d;
  logic [AW-1:0]                      dst_q, dst_d;
  logic                               rdc_bad_q, rdc_bad_d;
  logic [VECTOR_LANES-1:0]            wr_en_q, wr_en_d;
  logic [AW-1:0]                      wr_addr_q, wr_addr_d;
  logic [VECTOR_LANES*DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                               illegal_q, illegal_d;
  logic                               busy_q, busy_d;

  logic                               accept_s;
  vex_op_t                            op_s;
  logic [DATA_WIDTH-1:0]              seed_s;
  logic [DATA_WIDTH-1:0]              fold_s;
  logic [VECTOR_LANES*DATA_WIDTH-1:0] elem_res_s;
  logic                               unused_info_s;

  assign accept_s      = bus.valid_i & (state_q != S_RDC_WB);
  assign op_s          = vex_decode(bus.info_i.funct6, bus.info_i.is_rdc);
  assign seed_s        = (state_q == S_RDC) ? acc_q : bus.data_i[0].data1[DATA_WIDTH-1:0];
  assign unused_info_s = ^{bus.info_i.funct3, bus.info_i.vl};

  // Each lane's ALU takes data1 for element ops, or the running fold for reductions,
  // so the same lane ALUs form the reduction chain over valid lanes.
  for (genvar k = 0; k < VECTOR_LANES; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] prev_s;
    logic [DATA_WIDTH-1:0] a_s;
    logic [DATA_WIDTH-1:0] res_s;
    logic [DATA_WIDTH-1:0] chain_s;

    if (k == 0) begin : g_first
      assign prev_s = seed_s;
    end else begin : g_next
      assign prev_s = g_lane[k-1].chain_s;
    end

    assign a_s     = bus.info_i.is_rdc ? prev_s : bus.data_i[k].data1[DATA_WIDTH-1:0];
    assign chain_s = bus.data_i[k].valid ? res_s : prev_s;
    assign elem_res_s[k*DATA_WIDTH +: DATA_WIDTH] = res_s;

    vex_int_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .op_i  (op_s),
      .a_i   (a_s),
      .b_i   (bus.data_i[k].data2[DATA_WIDTH-1:0]),
      .res_o (res_s)
    );
  end

  assign fold_s = g_lane[VECTOR_LANES-1].chain_s;

  // Next-state, accumulator and writeback computation.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    dst_d     = dst_q;
    rdc_bad_d = rdc_bad_q;
    wr_en_d   = '0;
    wr_addr_d = '0;
    wr_data_d = '0;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE, S_RDC: begin
        if (accept_s && bus.info_i.is_rdc) begin
          if ((state_q == S_RDC) || bus.info_i.head_uop) begin
            acc_d     = fold_s;
            dst_d     = bus.info_i.dst[AW-1:0];
            rdc_bad_d = ((state_q == S_RDC) & rdc_bad_q) | (op_s == OP_BAD);
            state_d   = bus.info_i.end_uop ? S_RDC_WB : S_RDC;
          end else begin
            state_d = state_q;
          end
        end else if (accept_s) begin
          for (int k = 0; k < VECTOR_LANES; k++) begin
            wr_en_d[k] = bus.data_i[k].valid & bus.data_i[k].mask;
          end
          wr_addr_d = bus.info_i.dst[AW-1:0];
          wr_data_d = elem_res_s;
          illegal_d = (op_s == OP_BAD);
        end else begin
          state_d = state_q;
        end
      end
      S_RDC_WB: begin
        wr_en_d[0]               = 1'b1;
        wr_addr_d                = dst_q;
        wr_data_d[DATA_WIDTH-1:0] = acc_q;
        illegal_d                = rdc_bad_q;
        rdc_bad_d                = 1'b0;
        state_d                  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE) | (|wr_en_d);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      dst_q     <= '0;
      rdc_bad_q <= 1'b0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      dst_q     <= dst_d;
      rdc_bad_q <= rdc_bad_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ready_o   = (state_q != S_RDC_WB);
  assign bus.wr_en_o   = wr_en_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = wr_data_q;
  assign bus.illegal_o = illegal_q;
  assign bus.busy_o    = busy_q;

endmodule

// File: tb/tb_vex_int.sv
// Randomized self-checking bench for vex_int against a lane-by-lane arithmetic model.
module tb_vex_int;
  import cellrv32_package::*;

  localparam int NL = 8;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam logic [5:0] ELEM_F6 [11] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07,
                                          6'h09, 6'h0A, 6'h0B, 6'h25, 6'h17};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vex_int_if #(.VECTOR_REGISTERS(NR), .VECTOR_LANES(NL), .DATA_WIDTH(DW)) bus ();
  vex_int #(.VECTOR_REGISTERS(NR), .VECTOR_LANES(NL), .DATA_WIDTH(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [NL-1:0]    st_valid, st_mask;
  logic [DW-1:0]    st_d1 [NL];
  logic [DW-1:0]    st_d2 [NL];
  logic [NL-1:0]    exp_en;
  logic [NL*DW-1:0] exp_data;
  logic             exp_ill;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.info_i  = '0;
  endtask

  task automatic set_uop(input logic [5:0] f6, input logic [4:0] dst,
                         input logic rdc, input logic head, input logic endu);
    bus.valid_i          = 1'b1;
    bus.info_i           = '0;
    bus.info_i.funct6    = f6;
    bus.info_i.dst       = dst;
    bus.info_i.is_rdc    = rdc;
    bus.info_i.head_uop  = head;
    bus.info_i.end_uop   = endu;
    bus.info_i.vl        = 8'(NL);
    for (int k = 0; k < NL; k++) begin
      bus.data_i[k].valid = st_valid[k];
      bus.data_i[k].mask  = st_mask[k];
      bus.data_i[k].data1 = st_d1[k];
      bus.data_i[k].data2 = st_d2[k];
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    int t;
    if ($urandom_range(0, 1) == 1) return $urandom;
    t = int'($urandom_range(0, 40)) - 20;
    return t;
  endfunction

  task automatic rand_lanes();
    for (int k = 0; k < NL; k++) begin
      st_valid[k] = 1'($urandom);
      st_mask[k]  = 1'($urandom);
      st_d1[k]    = rand_word();
      st_d2[k]    = rand_word();
    end
  endtask

  // Element op model: {supported, data2 op data1}.
  function automatic logic [DW:0] ref_elem(input logic [5:0] f6, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (f6)
      6'h00: r = b + a;
      6'h02: r = b - a;
      6'h09: r = b & a;
      6'h0A: r = b | a;
      6'h0B: r = b ^ a;
      6'h04: r = (b < a) ? b : a;
      6'h05: r = ($signed(b) < $signed(a)) ? b : a;
      6'h06: r = (b > a) ? b : a;
      6'h07: r = ($signed(b) > $signed(a)) ? b : a;
`ifdef CELLRV32_VEX_MUL_EN
      6'h25: r = b * a;
`endif
      default: return {1'b0, {DW{1'b0}}};
    endcase
    return {1'b1, r};
  endfunction

  // Reduction model: vredsum, vredand, vredor, vredxor, vredminu, vredmin, vredmaxu, vredmax.
  function automatic logic [DW-1:0] ref_red(input int op, input logic [DW-1:0] acc,
                                            input logic [DW-1:0] b);
    case (op)
      0: return acc + b;
      1: return acc & b;
      2: return acc | b;
      3: return acc ^ b;
      4: return (b < acc) ? b : acc;
      5: return ($signed(b) < $signed(acc)) ? b : acc;
      6: return (b > acc) ? b : acc;
      7: return ($signed(b) > $signed(acc)) ? b : acc;
      default: return acc;
    endcase
  endfunction

  function automatic logic [NL*DW-1:0] lane_mask(input logic [NL-1:0] en);
    logic [NL*DW-1:0] m;
    m = '0;
    for (int k = 0; k < NL; k++) if (en[k]) m[k*DW +: DW] = {DW{1'b1}};
    return m;
  endfunction

  task automatic predict_elem(input logic [5:0] f6);
    logic [DW:0] r;
    exp_ill = 1'b0;
    for (int k = 0; k < NL; k++) begin
      r = ref_elem(f6, st_d1[k], st_d2[k]);
      exp_en[k] = st_valid[k] & st_mask[k];
      exp_data[k*DW +: DW] = r[DW-1:0];
      exp_ill = ~r[DW];
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (bus.wr_en_o !== '0 || bus.wr_addr_o !== '0 || bus.wr_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_wr: en=%h addr=%0d data=%h, required all zero",
               bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o);
    end
    n_tests++;
    if (bus.illegal_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctl: ill=%b busy=%b ready=%b, required 0 0 1",
               bus.illegal_o, bus.busy_o, bus.ready_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_vadd();
    logic [DW-1:0] lane;
    st_valid = '1;
    st_mask  = '1;
    for (int k = 0; k < NL; k++) begin st_d1[k] = 1; st_d2[k] = k; end
    set_uop(6'h00, 5'd3, 1'b0, 1'b0, 1'b0);
    step();
    idle_inputs();
    n_tests++;
    if (bus.wr_en_o !== 8'hFF || bus.wr_addr_o !== 5'd3) begin
      n_fail++;
      $display("FAIL vadd_en: en=%h addr=%0d, required ff 3", bus.wr_en_o, bus.wr_addr_o);
    end
    for (int k = 0; k < NL; k++) begin
      lane = bus.wr_data_o[k*DW +: DW];
      n_tests++;
      if (lane !== DW'(k + 1)) begin
        n_fail++;
        $display("FAIL vadd_lane%0d: got %0d, required %0d", k, lane, k + 1);
      end
    end
    step();
    n_tests++;
    if (bus.wr_en_o !== '0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_wb: en=%h busy=%b, required 0 0", bus.wr_en_o, bus.busy_o);
    end
  endtask

  task automatic test_corners();
    logic [5:0]    f6 [3]  = '{6'h02, 6'h05, 6'h04};
    logic [DW-1:0] d1 [3]  = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [DW-1:0] d2 [3]  = '{32'd0, 32'd5, 32'd5};
    logic [DW-1:0] exp [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
    for (int i = 0; i < 3; i++) begin
      st_valid = 8'h01;
      st_mask  = 8'h01;
      for (int k = 0; k < NL; k++) begin st_d1[k] = d1[i]; st_d2[k] = d2[i]; end
      set_uop(f6[i], 5'd7, 1'b0, 1'b0, 1'b0);
      step();
      idle_inputs();
      n_tests++;
      if (bus.wr_en_o !== 8'h01 || bus.wr_data_o[DW-1:0] !== exp[i]) begin
        n_fail++;
        $display("FAIL corner[%0d]: en=%h lane0=%h, required 01 %h",
                 i, bus.wr_en_o, bus.wr_data_o[DW-1:0], exp[i]);
      end
    end
  endtask

  task automatic test_mask_and_illegal();
    st_valid = 8'h0F;
    st_mask  = 8'hFD;
    for (int k = 0; k < NL; k++) begin st_d1[k] = 2; st_d2[k] = 3; end
    set_uop(6'h0B, 5'd1, 1'b0, 1'b0, 1'b0);
    step();
    n_tests++;
    if (bus.wr_en_o !== 8'h0D || bus.illegal_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mask: en=%h ill=%b, required 0d 0", bus.wr_en_o, bus.illegal_o);
    end
    st_valid = 8'hF0;
    st_mask  = 8'hFF;
    set_uop(6'h17, 5'd9, 1'b0, 1'b0, 1'b0);
    step();
    idle_inputs();
    n_tests++;
    if (bus.wr_en_o !== 8'hF0 || bus.wr_data_o !== '0 || bus.illegal_o !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal: en=%h data=%h ill=%b, required f0 0 1",
               bus.wr_en_o, bus.wr_data_o, bus.illegal_o);
    end
    step();
    n_tests++;
    if (bus.illegal_o !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse: ill=%b, required 0", bus.illegal_o);
    end
    st_valid = 8'h01;
    st_mask  = 8'h01;
    st_d1[0] = 3;
    st_d2[0] = 4;
    set_uop(6'h25, 5'd2, 1'b0, 1'b0, 1'b0);
    step();
    idle_inputs();
    n_tests++;
`ifdef CELLRV32_VEX_MUL_EN
    if (bus.wr_data_o[DW-1:0] !== 32'd12 || bus.illegal_o !== 1'b0) begin
      n_fail++;
      $display("FAIL vmul: lane0=%0d ill=%b, required 12 0", bus.wr_data_o[DW-1:0], bus.illegal_o);
    end
`else
    if (bus.wr_data_o[DW-1:0] !== 32'd0 || bus.illegal_o !== 1'b1 || bus.wr_en_o !== 8'h01) begin
      n_fail++;
      $display("FAIL vmul_off: lane0=%0d ill=%b en=%h, required 0 1 01",
               bus.wr_data_o[DW-1:0], bus.illegal_o, bus.wr_en_o);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [5:0] f6;
    logic [4:0] dst;
    logic [NL*DW-1:0] m;
    for (int i = 0; i < 40; i++) begin
      rand_lanes();
      f6  = ELEM_F6[$urandom_range(0, 10)];
      dst = 5'($urandom);
      predict_elem(f6);
      set_uop(f6, dst, 1'b0, 1'b0, 1'b0);
      step();
      m = lane_mask(exp_en);
      n_tests++;
      if (bus.wr_en_o !== exp_en || (bus.wr_data_o & m) !== (exp_data & m) ||
          bus.wr_addr_o !== dst || bus.illegal_o !== exp_ill) begin
        n_fail++;
        $display("FAIL b2b[%0d] f6=%h: en=%h addr=%0d ill=%b data=%h, required en=%h addr=%0d ill=%b data=%h",
                 i, f6, bus.wr_en_o, bus.wr_addr_o, bus.illegal_o, bus.wr_data_o & m,
                 exp_en, dst, exp_ill, exp_data & m);
      end
    end
    idle_inputs();
    step();
    n_tests++;
    if (bus.wr_en_o !== '0) begin
      n_fail++;
      $display("FAIL b2b_drain: en=%h, required 0", bus.wr_en_o);
    end
  endtask

  task automatic test_rdc_directed();
    logic [NL*DW-1:0] exp_wb;
    st_valid = '1;
    st_mask  = '1;
    for (int k = 0; k < NL; k++) begin st_d1[k] = (k == 0) ? 10 : 0; st_d2[k] = k + 1; end
    set_uop(6'h00, 5'd4, 1'b1, 1'b1, 1'b0);
    step();
    n_tests++;
    if (bus.wr_en_o !== '0 || bus.ready_o !== 1'b1 || bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rdc_head: en=%h ready=%b busy=%b, required 0 1 1",
               bus.wr_en_o, bus.ready_o, bus.busy_o);
    end
    set_uop(6'h00, 5'd4, 1'b1, 1'b0, 1'b1);
    step();
    idle_inputs();
    n_tests++;
    if (bus.wr_en_o !== '0 || bus.ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rdc_end: en=%h ready=%b, required 0 0", bus.wr_en_o, bus.ready_o);
    end
    step();
    exp_wb = '0;
    exp_wb[DW-1:0] = 32'd82;
    n_tests++;
    if (bus.wr_en_o !== 8'h01 || bus.wr_data_o !== exp_wb || bus.wr_addr_o !== 5'd4 ||
        bus.ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL vredsum: en=%h addr=%0d data=%h ready=%b, required 01 4 %h 1",
               bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o, bus.ready_o, exp_wb);
    end
    step();
    n_tests++;
    if (bus.wr_en_o !== '0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rdc_after: en=%h busy=%b, required 0 0", bus.wr_en_o, bus.busy_o);
    end
  endtask

  task automatic test_rdc_random();
    int op;
    int nu;
    logic [4:0] dst;
    logic [4:0] edst;
    logic [DW-1:0] acc;
    logic [NL*DW-1:0] exp_wb;
    logic [NL*DW-1:0] m;
    for (int r = 0; r < 12; r++) begin
      op  = int'($urandom_range(0, 7));
      nu  = int'($urandom_range(1, 3));
      dst = 5'($urandom);
      acc = '0;
      for (int u = 0; u < nu; u++) begin
        rand_lanes();
        if (u == 0) acc = st_d1[0];
        for (int k = 0; k < NL; k++) if (st_valid[k]) acc = ref_red(op, acc, st_d2[k]);
        set_uop(6'(op), dst, 1'b1, u == 0, u == nu - 1);
        step();
        if (u < nu - 1 && $urandom_range(0, 1) == 1) begin
          rand_lanes();
          edst = 5'($urandom);
          predict_elem(6'h00);
          set_uop(6'h00, edst, 1'b0, 1'b0, 1'b0);
          step();
          m = lane_mask(exp_en);
          n_tests++;
          if (bus.wr_en_o !== exp_en || (bus.wr_data_o & m) !== (exp_data & m) ||
              bus.wr_addr_o !== edst) begin
            n_fail++;
            $display("FAIL rdc_mid_elem[%0d]: en=%h addr=%0d data=%h, required en=%h addr=%0d data=%h",
                     r, bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o & m, exp_en, edst, exp_data & m);
          end
        end
      end
      idle_inputs();
      n_tests++;
      if (bus.ready_o !== 1'b0 || bus.wr_en_o === 8'h01) begin
        n_fail++;
        $display("FAIL rdc_rand_wb_early[%0d]: ready=%b en=%h, required ready 0 and no lane0 wb",
                 r, bus.ready_o, bus.wr_en_o);
      end
      step();
      exp_wb = '0;
      exp_wb[DW-1:0] = acc;
      n_tests++;
      if (bus.wr_en_o !== 8'h01 || bus.wr_data_o !== exp_wb || bus.wr_addr_o !== dst ||
          bus.illegal_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rdc_rand[%0d] op=%0d n=%0d: en=%h addr=%0d lane0=%h ill=%b, required 01 %0d %h 0",
                 r, op, nu, bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o[DW-1:0], bus.illegal_o,
                 dst, acc);
      end
    end
  endtask

  task automatic test_reset_mid_rdc();
    rand_lanes();
    st_valid = '1;
    set_uop(6'h00, 5'd6, 1'b1, 1'b1, 1'b0);
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.wr_en_o !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_rdc: ready=%b busy=%b en=%h, required 1 0 0",
               bus.ready_o, bus.busy_o, bus.wr_en_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (bus.wr_en_o !== '0 || bus.busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_rdc_quiet[%0d]: en=%h busy=%b, required 0 0", i, bus.wr_en_o, bus.busy_o);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_vadd();
    test_corners();
    test_mask_and_illegal();
    test_back_to_back();
    test_rdc_directed();
    test_rdc_random();
    test_reset_mid_rdc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
